// File: rtl/regfile_dump.sv
// regfile_dump: 2R/1W register file with byte enables, probe port and a valid/ready dump engine.
// Define REGFILE_BYPASS_EN to forward same-cycle writes to rd1/rd2/probe.
module regfile_dump #(
    parameter int DATA_W     = 32,
    parameter int DEPTH      = 32,
    parameter int ADDR_W     = $clog2(DEPTH),
    parameter int ZERO_REG   = 0,
    parameter int INIT_INDEX = 1,
    parameter int PROBE_IDX  = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_W-1:0]     ra1,
    input  logic [ADDR_W-1:0]     ra2,
    output logic [DATA_W-1:0]     rd1,
    output logic [DATA_W-1:0]     rd2,
    input  logic [ADDR_W-1:0]     wa,
    input  logic [DATA_W-1:0]     wd,
    input  logic                  we,
    input  logic [DATA_W/8-1:0]   wbe,
    output logic [DATA_W-1:0]     probe,
    input  logic                  dump_req,
    output logic                  dump_busy,
    output logic                  dump_valid,
    input  logic                  dump_ready,
    output logic [ADDR_W-1:0]     dump_addr,
    output logic [DATA_W-1:0]     dump_data,
    output logic                  dump_last
);
    localparam int NB = DATA_W / 8;
    localparam logic [ADDR_W:0]   DEPTH_V = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] PROBE_A = ADDR_W'(PROBE_IDX);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] SEND = 1'b1;

    logic [DATA_W-1:0] regs [DEPTH];
    logic [0:0]        state;
    logic [ADDR_W-1:0] idx;
    logic              wr_ok;
    logic [ADDR_W-1:0] raddr [3];
    logic [DATA_W-1:0] rdat  [3];

    // an address is live if it exists and is not the hard-wired zero register
    function automatic logic live(input logic [ADDR_W-1:0] a);
        return ({1'b0, a} < DEPTH_V) && !(ZERO_REG != 0 && a == '0);
    endfunction

    function automatic logic [DATA_W-1:0] merge(input logic [DATA_W-1:0] old_v,
                                                input logic [DATA_W-1:0] new_v,
                                                input logic [NB-1:0] be);
        logic [DATA_W-1:0] r;
        r = old_v;
        for (int b = 0; b < NB; b++)
            if (be[b]) r[8*b +: 8] = new_v[8*b +: 8];
        return r;
    endfunction

    assign wr_ok = we && live(wa);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++)
                regs[i] <= (INIT_INDEX != 0 && !(ZERO_REG != 0 && i == 0)) ? DATA_W'(i) : '0;
        end else if (wr_ok) begin
            regs[wa] <= merge(regs[wa], wd, wbe);
        end
    end

    assign raddr[0] = ra1;
    assign raddr[1] = ra2;
    assign raddr[2] = PROBE_A;

    for (genvar p = 0; p < 3; p++) begin : g_rd
        logic [DATA_W-1:0] stored;
        assign stored = live(raddr[p]) ? regs[raddr[p]] : '0;
`ifdef REGFILE_BYPASS_EN
        assign rdat[p] = (wr_ok && wa == raddr[p]) ? merge(stored, wd, wbe) : stored;
`else
        assign rdat[p] = stored;
`endif
    end

    assign rd1   = rdat[0];
    assign rd2   = rdat[1];
    assign probe = rdat[2];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            idx   <= '0;
        end else if (state == IDLE) begin
            state <= dump_req ? SEND : IDLE;
            idx   <= '0;
        end else if (dump_ready) begin
            state <= (idx == LAST) ? IDLE : SEND;
            idx   <= (idx == LAST) ? '0 : idx + 1'b1;
        end
    end

    // dump reads stored state only; same-cycle writes appear on the next beat cycle
    assign dump_busy  = state == SEND;
    assign dump_valid = state == SEND;
    assign dump_addr  = idx;
    assign dump_last  = state == SEND && idx == LAST;
    assign dump_data  = live(idx) ? regs[idx] : '0;
endmodule

// File: tb/tb_regfile_dump.sv
// tb_regfile_dump: scoreboard bench for regfile_dump (default parameters plus a ZERO_REG=1 instance).
module tb_regfile_dump;
    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  ra1, ra2, wa;
    logic [31:0] wd;
    logic        we;
    logic [3:0]  wbe;
    logic        dump_req, dump_ready;
    logic [31:0] rd1, rd2, probe, dump_data;
    logic        dump_busy, dump_valid, dump_last;
    logic [4:0]  dump_addr;
    logic [31:0] rd1_z, rd2_z, probe_z, dz_data;
    logic        dz_busy, dz_valid, dz_last;
    logic [4:0]  dz_addr;

    int vectors = 0;
    int miscompares = 0;
    logic [31:0] mdl [32];

    typedef struct {
        logic [4:0]  a;
        logic [31:0] d;
        logic        l;
    } beat_t;
    beat_t q [$];

    always #5 clk = ~clk;

    regfile_dump u_dut (
        .clk(clk), .rst(rst), .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
        .wa(wa), .wd(wd), .we(we), .wbe(wbe), .probe(probe),
        .dump_req(dump_req), .dump_busy(dump_busy), .dump_valid(dump_valid),
        .dump_ready(dump_ready), .dump_addr(dump_addr), .dump_data(dump_data),
        .dump_last(dump_last)
    );

    regfile_dump #(.ZERO_REG(1)) u_z (
        .clk(clk), .rst(rst), .ra1(ra1), .ra2(ra2), .rd1(rd1_z), .rd2(rd2_z),
        .wa(wa), .wd(wd), .we(we), .wbe(wbe), .probe(probe_z),
        .dump_req(1'b0), .dump_busy(dz_busy), .dump_valid(dz_valid),
        .dump_ready(1'b1), .dump_addr(dz_addr), .dump_data(dz_data),
        .dump_last(dz_last)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic mdl_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] be);
        for (int b = 0; b < 4; b++)
            if (be[b]) mdl[a][8*b +: 8] = d[8*b +: 8];
    endtask

    task automatic mdl_reset();
        for (int i = 0; i < 32; i++) mdl[i] = i;
    endtask

    task automatic queue_dump();
        for (int i = 0; i < 32; i++) q.push_back('{a: 5'(i), d: mdl[i], l: (i == 31)});
    endtask

    initial begin
        int it;
        beat_t e;
        rst = 1'b0; ra1 = '0; ra2 = '0; wa = '0; wd = '0; we = 1'b0; wbe = '0;
        dump_req = 1'b0; dump_ready = 1'b0;
        mdl_reset();
        repeat (2) @(negedge clk);
        #1;
        chk("rst_busy", dump_busy, 0);
        chk("rst_valid", dump_valid, 0);
        chk("rst_last", dump_last, 0);
        chk("rst_addr", dump_addr, 0);
        @(negedge clk);
        rst = 1'b1; ra1 = 5'd5; ra2 = 5'd31;
        #1;
        chk("rd1_init", rd1, 5);
        chk("rd2_init", rd2, 31);
        chk("probe_init", probe, 1);
        chk("valid_idle", dump_valid, 0);
        @(negedge clk);
        ra1 = 5'd9; ra2 = 5'd9;
        #1;
        chk("same_rd1", rd1, mdl[9]);
        chk("same_rd2", rd2, mdl[9]);

        // byte-enable write to reg 3
        @(negedge clk);
        we = 1'b1; wa = 5'd3; wd = 32'hAABBCCDD; wbe = 4'b0101; ra1 = 5'd3;
        #1;
`ifdef REGFILE_BYPASS_EN
        chk("byte_same_cyc", rd1, 32'h00BB00DD);
`else
        chk("byte_same_cyc", rd1, 32'h3);
`endif
        mdl_write(3, 32'hAABBCCDD, 4'b0101);
        @(negedge clk);
        we = 1'b0;
        #1;
        chk("byte_write", rd1, mdl[3]);
        chk("byte_write_k", rd1, 32'h00BB00DD);

        // we with no byte enables
        @(negedge clk);
        we = 1'b1; wa = 5'd4; wd = 32'hFFFFFFFF; wbe = 4'h0; ra1 = 5'd4;
        @(negedge clk);
        we = 1'b0;
        #1;
        chk("wbe_zero", rd1, 4);

        // bypass behaviour
        @(negedge clk);
        we = 1'b1; wa = 5'd7; wd = 32'h12345678; wbe = 4'hF; ra1 = 5'd7; ra2 = 5'd6;
        #1;
`ifdef REGFILE_BYPASS_EN
        chk("bypass_rd1", rd1, 32'h12345678);
`else
        chk("bypass_rd1", rd1, 32'h7);
`endif
        chk("bypass_other", rd2, 6);
        mdl_write(7, 32'h12345678, 4'hF);
        @(negedge clk);
        we = 1'b0;
        #1;
        chk("bypass_next", rd1, mdl[7]);

        // zero register: the ZERO_REG instance drops it, the default one stores it
        @(negedge clk);
        we = 1'b1; wa = 5'd0; wd = 32'hFFFFFFFF; wbe = 4'hF; ra1 = 5'd0;
        #1;
        chk("zero_same_cyc", rd1_z, 0);
        mdl_write(0, 32'hFFFFFFFF, 4'hF);
        @(negedge clk);
        we = 1'b0;
        #1;
        chk("zero_rd1", rd1_z, 0);
        chk("zero_probe", probe_z, 1);
        chk("nonzero_rd1", rd1, mdl[0]);

        // probe follows writes to reg 1
        @(negedge clk);
        we = 1'b1; wa = 5'd1; wd = 32'hCAFE0001; wbe = 4'b1100;
        mdl_write(1, 32'hCAFE0001, 4'b1100);
        @(negedge clk);
        we = 1'b0;
        #1;
        chk("probe_write", probe, mdl[1]);

        // reset restores index values
        @(negedge clk);
        rst = 1'b0; ra1 = 5'd3;
        #1;
        chk("reset_restore", rd1, 3);
        mdl_reset();
        @(negedge clk);
        rst = 1'b1;

        // full dump with alternating backpressure
        @(negedge clk);
        dump_req = 1'b1;
        queue_dump();
        @(negedge clk);
        dump_req = 1'b0;
        #1;
        chk("dump_latency", dump_valid, 1);
        it = 0;
        while (q.size() > 0 && it < 200) begin
            if (it > 0) @(negedge clk);
            dump_ready = (it % 2 == 0);
            dump_req = (it == 5);
            #1;
            chk("dump_busy", dump_busy, 1);
            if (dump_valid && dump_ready) begin
                e = q.pop_front();
                chk("dump_addr", dump_addr, e.a);
                chk("dump_data", dump_data, e.d);
                chk("dump_last", dump_last, e.l);
            end else begin
                chk("stall_last", dump_last, (dump_addr == 5'd31));
            end
            it++;
        end
        chk("dump_cycles", it, 63);
        chk("dump_drained", q.size(), 0);
        @(negedge clk);
        dump_ready = 1'b0; dump_req = 1'b0;
        #1;
        chk("post_busy", dump_busy, 0);
        chk("post_valid", dump_valid, 0);
        chk("post_addr", dump_addr, 0);

        // reset in the middle of a dump
        @(negedge clk);
        we = 1'b1; wa = 5'd2; wd = 32'h0000DEAD; wbe = 4'hF; ra1 = 5'd2;
        @(negedge clk);
        we = 1'b0; dump_req = 1'b1;
        @(negedge clk);
        dump_req = 1'b0; dump_ready = 1'b1;
        #1;
        chk("mid_written", rd1, 32'h0000DEAD);
        it = 0;
        while (dump_addr != 5'd10 && it < 50) begin
            @(negedge clk);
            #1;
            it++;
        end
        chk("mid_reach10", dump_addr, 10);
        rst = 1'b0;
        #1;
        chk("mid_valid", dump_valid, 0);
        chk("mid_busy", dump_busy, 0);
        chk("mid_regs", rd1, 2);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk("no_resume", dump_valid, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
